// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory stage: access size codes, FSM states
// and the misalignment rule used when DMEM_MISALIGN_TRAP_EN is defined.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'b00,
    DMEM_WAIT   = 2'b01,
    DMEM_ACCESS = 2'b10
  } dmem_state_t;

  // Half at an odd address, word off a 4-byte boundary, or the reserved size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bundle of the data-memory stage.
// Handshake: the CPU raises req with we/size/sign_ext/addr/wdata valid; the
// unit samples them only while idle (busy=0) and answers with a one-cycle
// ready pulse, qualifying misalign and the registered DMOut in that cycle.
// dbg_state mirrors the FSM state for observation.
interface data_mem_unit_if;
  import dmem_pkg::*;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] DMOut;
  logic        ready;
  logic        busy;
  logic        misalign;
  dmem_state_t dbg_state;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  DMOut, ready, busy, misalign, dbg_state
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output DMOut, ready, busy, misalign, dbg_state
  );

endinterface

// File: rtl/dmem_lane.sv
// Big-endian byte-lane steering: byte enables and replicated write data for
// stores, plus extraction and sign/zero extension for loads. Purely
// combinational; expects an address already aligned for the given size.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        sign_ext,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [1:0]  byte_sel;

  // Offset 0 lives in bits 31:24, so lane index is the inverted offset.
  always_comb begin
    byte_sel = ~addr_lo;
    byte_v   = rword[{byte_sel, 3'b000} +: 8];
    half_v   = addr_lo[1] ? rword[15:0] : rword[31:16];
    be       = 4'b0000;
    wword    = 32'h0;
    rdata    = 32'h0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b1000 >> addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be    = addr_lo[1] ? 4'b0011 : 4'b1100;
        wword = {2{wdata[15:0]}};
        rdata = {{16{sign_ext & half_v[15]}}, half_v};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: byte-addressable big-endian RAM behind a req/ready
// handshake with WAIT_CYCLES programmable wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are rejected
// with misalign=1; otherwise low address bits are truncated to alignment.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 1
) (
  input logic            CLK,
  input logic            RST,
  data_mem_unit_if.slave bus
);

  localparam int         AW      = $clog2(DEPTH_BYTES);
  localparam int         WORDS   = DEPTH_BYTES / 4;
  localparam int         WIW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [31:0] mem [WORDS];

  dmem_state_t state, state_n;
  logic [3:0]  cnt;

  logic          cap_we, cap_sext, cap_mis;
  logic [1:0]    cap_size;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wdata;

  logic [31:0] dmout_q;
  logic        ready_q, mis_q;

  logic          req_mis;
  logic [1:0]    req_size;
  logic [AW-1:0] req_idx;

  logic [WIW-1:0] word_idx;
  logic [3:0]     lane_be;
  logic [31:0]    lane_wword, lane_rdata;

  // Decode the incoming request into the form that gets captured.
  always_comb begin
    req_idx  = bus.addr[AW-1:0];
    req_size = bus.size;
    req_mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    req_mis  = is_misaligned(bus.size, bus.addr[1:0]);
`else
    if (bus.size == SZ_RSVD) req_size = SZ_WORD;
    if (req_size == SZ_HALF) req_idx[0] = 1'b0;
    else if (req_size == SZ_WORD) req_idx[1:0] = 2'b00;
`endif
  end

  assign word_idx = WIW'(cap_idx >> 2);

  dmem_lane u_lane (
    .size     (cap_size),
    .addr_lo  (cap_idx[1:0]),
    .wdata    (cap_wdata),
    .sign_ext (cap_sext),
    .rword    (mem[word_idx]),
    .be       (lane_be),
    .wword    (lane_wword),
    .rdata    (lane_rdata)
  );

  // Next-state logic; rejected accesses bypass the wait states.
  always_comb begin
    state_n = state;
    case (state)
      DMEM_IDLE:   if (bus.req) state_n = (req_mis || WAIT_LD == 4'd0) ? DMEM_ACCESS : DMEM_WAIT;
      DMEM_WAIT:   if (cnt == 4'd1) state_n = DMEM_ACCESS;
      DMEM_ACCESS: state_n = DMEM_IDLE;
      default:     state_n = DMEM_IDLE;
    endcase
  end

  // State, wait counter, request capture and registered completion outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_sext  <= 1'b0;
      cap_mis   <= 1'b0;
      cap_size  <= SZ_BYTE;
      cap_idx   <= '0;
      cap_wdata <= 32'h0;
      dmout_q   <= 32'h0;
      ready_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      case (state)
        DMEM_IDLE: begin
          if (bus.req) begin
            cap_we    <= bus.we;
            cap_sext  <= bus.sign_ext;
            cap_mis   <= req_mis;
            cap_size  <= req_size;
            cap_idx   <= req_idx;
            cap_wdata <= bus.wdata;
            cnt       <= WAIT_LD;
          end
        end
        DMEM_WAIT: cnt <= cnt - 4'd1;
        DMEM_ACCESS: begin
          ready_q <= 1'b1;
          mis_q   <= cap_mis;
          if (!cap_mis && !cap_we) dmout_q <= lane_rdata;
        end
        default: ;
      endcase
    end
  end

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (state == DMEM_ACCESS && cap_we && !cap_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[word_idx][8*i +: 8] <= lane_wword[8*i +: 8];
      end
    end
  end

  assign bus.DMOut     = dmout_q;
  assign bus.ready     = ready_q;
  assign bus.misalign  = mis_q;
  assign bus.busy      = (state != DMEM_IDLE);
  assign bus.dbg_state = state;

endmodule
